led_matrix_scanner: RTL and testbench
=====================================

LED_MATRIX_SCANNER -- requirements
Module: led_matrix_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1024, clock cycles per row slot; legal range is at least BLANK_CYCLES+2.
REQ-002 SHALL have parameter BLANK_CYCLES, default 16, cycles at the start of each row slot with all rows off.
REQ-003 SHALL have port clk_master, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_master, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports row_1_main..row_8_main, input, 8 bits each: frame image rows from the game core; bit i is column i.
REQ-006 SHALL have port display, input, 1 bit: frame-ready level from the game core; a rising edge marks a new frame.
REQ-007 SHALL have port row_sel, output, 8 bits: active-low one-hot row drive; bit n-1 drives matrix row n.
REQ-008 SHALL have port col_data, output, 8 bits: active-high column drive for the selected row.
REQ-009 SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of each full 8-row scan.
REQ-010 SHALL have port frame_overrun, output, 1 bit: sticky flag set when a pending frame is overwritten before it is displayed.

Function
REQ-011 SHALL register display into display_q; rise = display AND NOT display_q.
REQ-012 SHALL, on a cycle with rise, load all eight row_n_main values into the pending buffer and set pending_valid.
REQ-013 SHALL hold an active buffer of 8x8 bits, the only source for col_data; the pending buffer never drives outputs directly.
REQ-014 SHALL run a prescaler cnt counting 0..SCAN_DIV-1, wrapping to 0; slot_end = (cnt == SCAN_DIV-1).
REQ-015 SHALL keep a 3-bit row index, 0..7, incremented on slot_end and wrapping from 7 to 0.
REQ-016 SHALL implement FSM states BLANK and DRIVE: BLANK while cnt < BLANK_CYCLES, DRIVE while cnt >= BLANK_CYCLES; transitions are registered.
REQ-017 SHALL, in BLANK, drive row_sel = 8'hFF and col_data = 8'h00.
REQ-018 SHALL, in DRIVE, drive row_sel = ~(1 << row) and col_data = active buffer row[row]; outputs are registered, one cycle of latency from the state/row update.
REQ-019 SHALL define frame_end = slot_end AND row == 7, and pulse frame_done high for exactly the following cycle.
REQ-020 SHALL, on frame_end with pending_valid = 1, copy pending to active and clear pending_valid; the swap occurs only at frame_end, so no row is shown from a mixed frame.
REQ-021 SHALL, on frame_end with pending_valid = 0, leave active unchanged; the last frame repeats.
REQ-022 SHALL, when rise and frame_end coincide, swap the old pending contents into active and capture the new inputs into pending with pending_valid = 1; this is not an overrun.
REQ-023 SHALL, when rise and frame_end coincide with pending_valid = 0, capture into pending only; the frame is shown from the next frame_end, with no bypass.
REQ-024 SHALL set frame_overrun when rise occurs with pending_valid = 1 and no frame_end in the same cycle; the newest frame wins and the flag clears only on reset.
REQ-025 SHALL ignore a held-high display after its first rising edge; a new capture requires a low-to-high transition.

Reset
REQ-026 SHALL, while reset_master = 0, asynchronously force: cnt = 0, row = 0, state BLANK, display_q = 0, pending_valid = 0, both buffers all-zero, row_sel = 8'hFF, col_data = 8'h00, frame_done = 0, frame_overrun = 0.
REQ-027 SHALL, on reset release mid-scan, restart from row 0 slot start with blank output; no partial frame survives.
REQ-028 SHALL handle reset released synchronously to clk_master by the system; the first post-reset edge starts cnt counting from 0.

Verification (SCAN_DIV=8, BLANK_CYCLES=2)
REQ-029 SHALL cover reset defaults: hold reset_master = 0 -> row_sel = FF, col_data = 00, frame_done = 0, frame_overrun = 0; after release, output stays blank during cycles 0-1 of row 0.
REQ-030 SHALL cover a single frame: row_1_main = 81, row_8_main = 3C, others 00, one display rise -> after the next frame_end, row_sel = FE with col_data = 81 for 6 cycles per slot, and row_sel = 7F with col_data = 3C.
REQ-031 SHALL cover swap timing: display rise during row 3 -> active unchanged through row 7, new image from the following row 0, and frame_done pulses once every 64 cycles.
REQ-032 SHALL cover overrun: two rises within one frame, with data A then B -> B displayed, A never displayed, frame_overrun = 1 and remains 1.
REQ-033 SHALL cover coincidence: rise on the frame_end cycle with pending A valid -> A displayed now, new data B displayed next frame, frame_overrun = 0.
REQ-034 SHALL cover mid-operation reset: assert reset_master during row 5 DRIVE -> row_sel = FF immediately (asynchronously); after release, an all-zero image is shown until a new display rise is followed by a frame_end.

Source files
------------

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed 8x8 LED matrix driver with double-buffered frames.
// New images land in a pending buffer and go live only between full scans.
module led_matrix_scanner #(
    parameter int unsigned SCAN_DIV     = 1024,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic       clk_master,
    input  logic       reset_master,
    input  logic [7:0] row_1_main,
    input  logic [7:0] row_2_main,
    input  logic [7:0] row_3_main,
    input  logic [7:0] row_4_main,
    input  logic [7:0] row_5_main,
    input  logic [7:0] row_6_main,
    input  logic [7:0] row_7_main,
    input  logic [7:0] row_8_main,
    input  logic       display,
    output logic [7:0] row_sel,
    output logic [7:0] col_data,
    output logic       frame_done,
    output logic       frame_overrun
);

    localparam int unsigned CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;
    logic [2:0]      row;
    logic [2:0]      row_next;
    logic            display_q;
    logic            rise;
    logic            slot_end;
    logic            frame_end;
    logic            swap;
    logic            pending_valid;
    logic [7:0][7:0] pending_buf;
    logic [7:0][7:0] active_buf;
    logic [7:0][7:0] frame_in;
    logic [7:0]      row_sel_next;
    logic [7:0]      col_data_next;

    assign frame_in = {row_8_main, row_7_main, row_6_main, row_5_main,
                       row_4_main, row_3_main, row_2_main, row_1_main};

    assign rise      = display & ~display_q;
    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end & (row == 3'd7);
    assign swap      = frame_end & pending_valid;

    always_comb begin
        cnt_next   = slot_end ? '0 : cnt + CW'(1);
        row_next   = slot_end ? row + 3'd1 : row;
        state_next = (cnt_next < CNT_BLANK) ? BLANK : DRIVE;
    end

    always_ff @(posedge clk_master or negedge reset_master) begin
        if (!reset_master) begin
            state <= BLANK;
            cnt   <= '0;
            row   <= 3'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            row   <= row_next;
        end
    end

    always_ff @(posedge clk_master or negedge reset_master) begin
        if (!reset_master) begin
            display_q <= 1'b0;
        end else begin
            display_q <= display;
        end
    end

    // Rise at the swap cycle: old pending goes live, new image queues.
    always_ff @(posedge clk_master or negedge reset_master) begin
        if (!reset_master) begin
            pending_buf   <= '0;
            active_buf    <= '0;
            pending_valid <= 1'b0;
        end else begin
            if (swap) begin
                active_buf <= pending_buf;
            end
            if (rise) begin
                pending_buf   <= frame_in;
                pending_valid <= 1'b1;
            end else if (swap) begin
                pending_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_master or negedge reset_master) begin
        if (!reset_master) begin
            frame_overrun <= 1'b0;
        end else if (rise && pending_valid && !frame_end) begin
            frame_overrun <= 1'b1;
        end
    end

    always_comb begin
        row_sel_next  = 8'hFF;
        col_data_next = 8'h00;
        unique case (state)
            BLANK: begin
                row_sel_next  = 8'hFF;
                col_data_next = 8'h00;
            end
            DRIVE: begin
                row_sel_next  = ~(8'h01 << row);
                col_data_next = active_buf[row];
            end
            default: begin
                row_sel_next  = 8'hFF;
                col_data_next = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk_master or negedge reset_master) begin
        if (!reset_master) begin
            row_sel    <= 8'hFF;
            col_data   <= 8'h00;
            frame_done <= 1'b0;
        end else begin
            row_sel    <= row_sel_next;
            col_data   <= col_data_next;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner with SCAN_DIV=8, BLANK_CYCLES=2.
// Period p is the interval after the p-th clock edge following reset release.
module tb_led_matrix_scanner;

    logic       clk_master = 1'b0;
    logic       reset_master;
    logic [7:0] row_1_main, row_2_main, row_3_main, row_4_main;
    logic [7:0] row_5_main, row_6_main, row_7_main, row_8_main;
    logic       display;
    logic [7:0] row_sel;
    logic [7:0] col_data;
    logic       frame_done;
    logic       frame_overrun;

    int vec = 0;
    int err = 0;
    int p   = 0;

    always #5 clk_master = ~clk_master;

    led_matrix_scanner #(
        .SCAN_DIV(8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk_master(clk_master),
        .reset_master(reset_master),
        .row_1_main(row_1_main),
        .row_2_main(row_2_main),
        .row_3_main(row_3_main),
        .row_4_main(row_4_main),
        .row_5_main(row_5_main),
        .row_6_main(row_6_main),
        .row_7_main(row_7_main),
        .row_8_main(row_8_main),
        .display(display),
        .row_sel(row_sel),
        .col_data(col_data),
        .frame_done(frame_done),
        .frame_overrun(frame_overrun)
    );

    task automatic tick();
        @(posedge clk_master);
        #2;
        p++;
    endtask

    task automatic run_to(input int target);
        while (p < target) tick();
    endtask

    task automatic release_reset();
        @(posedge clk_master);
        #2;
        reset_master = 1'b1;
        p = 0;
    endtask

    task automatic test_reset();
        reset_master = 1'b1;
        display = 1'b0;
        {row_1_main, row_2_main, row_3_main, row_4_main} = '0;
        {row_5_main, row_6_main, row_7_main, row_8_main} = '0;
        #1 reset_master = 1'b0;
        #20;
        vec++; if (row_sel !== 8'hFF) begin err++; $display("FAIL rst_row_sel got %h want ff", row_sel); end
        vec++; if (col_data !== 8'h00) begin err++; $display("FAIL rst_col_data got %h want 00", col_data); end
        vec++; if (frame_done !== 1'b0) begin err++; $display("FAIL rst_frame_done got %b want 0", frame_done); end
        vec++; if (frame_overrun !== 1'b0) begin err++; $display("FAIL rst_overrun got %b want 0", frame_overrun); end
        release_reset();
        for (int i = 0; i < 3; i++) begin
            vec++; if (row_sel !== 8'hFF || col_data !== 8'h00) begin err++; $display("FAIL post_rst_blank p=%0d got %h/%h want ff/00", p, row_sel, col_data); end
            tick();
        end
        vec++; if (row_sel !== 8'hFE || col_data !== 8'h00) begin err++; $display("FAIL first_drive got %h/%h want fe/00", row_sel, col_data); end
    endtask

    task automatic test_single_frame();
        row_1_main = 8'h81;
        row_8_main = 8'h3C;
        display = 1'b1;
        run_to(5);
        display = 1'b0;
        run_to(63);
        vec++; if (frame_done !== 1'b0) begin err++; $display("FAIL fd_before got %b want 0", frame_done); end
        run_to(64);
        vec++; if (frame_done !== 1'b1) begin err++; $display("FAIL fd_pulse got %b want 1", frame_done); end
        vec++; if (row_sel !== 8'h7F || col_data !== 8'h00) begin err++; $display("FAIL old_row8 got %h/%h want 7f/00", row_sel, col_data); end
        run_to(65);
        vec++; if (frame_done !== 1'b0) begin err++; $display("FAIL fd_width got %b want 0", frame_done); end
        vec++; if (row_sel !== 8'hFF || col_data !== 8'h00) begin err++; $display("FAIL slot_blank got %h/%h want ff/00", row_sel, col_data); end
        run_to(67);
        for (int i = 0; i < 6; i++) begin
            vec++; if (row_sel !== 8'hFE || col_data !== 8'h81) begin err++; $display("FAIL row1_drive p=%0d got %h/%h want fe/81", p, row_sel, col_data); end
            tick();
        end
        vec++; if (row_sel !== 8'hFF || col_data !== 8'h00) begin err++; $display("FAIL row2_blank got %h/%h want ff/00", row_sel, col_data); end
        run_to(75);
        vec++; if (row_sel !== 8'hFD || col_data !== 8'h00) begin err++; $display("FAIL row2_drive got %h/%h want fd/00", row_sel, col_data); end
        run_to(123);
        vec++; if (row_sel !== 8'h7F || col_data !== 8'h3C) begin err++; $display("FAIL row8_drive got %h/%h want 7f/3c", row_sel, col_data); end
        run_to(128);
        vec++; if (row_sel !== 8'h7F || col_data !== 8'h3C) begin err++; $display("FAIL row8_last got %h/%h want 7f/3c", row_sel, col_data); end
        vec++; if (frame_overrun !== 1'b0) begin err++; $display("FAIL sf_overrun got %b want 0", frame_overrun); end
    endtask

    task automatic test_swap_timing();
        int pulses;
        run_to(154);
        row_1_main = 8'h55;
        row_8_main = 8'hAA;
        display = 1'b1;
        run_to(156);
        display = 1'b0;
        run_to(187);
        vec++; if (row_sel !== 8'h7F || col_data !== 8'h3C) begin err++; $display("FAIL swap_hold7 got %h/%h want 7f/3c", row_sel, col_data); end
        run_to(192);
        vec++; if (row_sel !== 8'h7F || col_data !== 8'h3C) begin err++; $display("FAIL swap_hold7_end got %h/%h want 7f/3c", row_sel, col_data); end
        pulses = 0;
        while (p < 256) begin
            tick();
            if (frame_done === 1'b1) pulses++;
            if (p == 195) begin
                vec++; if (row_sel !== 8'hFE || col_data !== 8'h55) begin err++; $display("FAIL swap_new1 got %h/%h want fe/55", row_sel, col_data); end
            end
            if (p == 251) begin
                vec++; if (row_sel !== 8'h7F || col_data !== 8'hAA) begin err++; $display("FAIL swap_new8 got %h/%h want 7f/aa", row_sel, col_data); end
            end
        end
        vec++; if (pulses !== 1) begin err++; $display("FAIL fd_per_frame got %0d want 1", pulses); end
    endtask

    task automatic test_coincidence();
        run_to(259);
        vec++; if (row_sel !== 8'hFE || col_data !== 8'h55) begin err++; $display("FAIL co_prev got %h/%h want fe/55", row_sel, col_data); end
        run_to(270);
        row_1_main = 8'h33;
        row_8_main = 8'h00;
        display = 1'b1;
        run_to(272);
        display = 1'b0;
        run_to(319);
        row_1_main = 8'h44;
        display = 1'b1;
        run_to(320);
        vec++; if (frame_done !== 1'b1) begin err++; $display("FAIL co_fd got %b want 1", frame_done); end
        run_to(322);
        display = 1'b0;
        run_to(323);
        vec++; if (row_sel !== 8'hFE || col_data !== 8'h33) begin err++; $display("FAIL co_a_now got %h/%h want fe/33", row_sel, col_data); end
        run_to(387);
        vec++; if (row_sel !== 8'hFE || col_data !== 8'h44) begin err++; $display("FAIL co_b_next got %h/%h want fe/44", row_sel, col_data); end
        vec++; if (frame_overrun !== 1'b0) begin err++; $display("FAIL co_overrun got %b want 0", frame_overrun); end
    endtask

    task automatic test_overrun();
        int hits;
        hits = 0;
        while (p < 512) begin
            tick();
            if (col_data === 8'h11) hits++;
            if (p == 390) begin
                row_1_main = 8'h11;
                display = 1'b1;
            end
            if (p == 392) display = 1'b0;
            if (p == 400) begin
                vec++; if (frame_overrun !== 1'b0) begin err++; $display("FAIL ov_early got %b want 0", frame_overrun); end
                row_1_main = 8'h22;
                display = 1'b1;
            end
            if (p == 401) begin
                vec++; if (frame_overrun !== 1'b1) begin err++; $display("FAIL ov_set got %b want 1", frame_overrun); end
            end
            if (p == 402) display = 1'b0;
            if (p == 451) begin
                vec++; if (row_sel !== 8'hFE || col_data !== 8'h22) begin err++; $display("FAIL ov_b_shown got %h/%h want fe/22", row_sel, col_data); end
            end
        end
        vec++; if (hits !== 0) begin err++; $display("FAIL ov_a_hidden got %0d want 0", hits); end
        vec++; if (frame_overrun !== 1'b1) begin err++; $display("FAIL ov_sticky got %b want 1", frame_overrun); end
    endtask

    task automatic test_mid_reset();
        run_to(556);
        vec++; if (row_sel !== 8'hDF || col_data !== 8'h00) begin err++; $display("FAIL mr_row6 got %h/%h want df/00", row_sel, col_data); end
        #1 reset_master = 1'b0;
        #1;
        vec++; if (row_sel !== 8'hFF || col_data !== 8'h00) begin err++; $display("FAIL mr_async got %h/%h want ff/00", row_sel, col_data); end
        vec++; if (frame_overrun !== 1'b0) begin err++; $display("FAIL mr_overrun got %b want 0", frame_overrun); end
        @(posedge clk_master);
        release_reset();
        run_to(3);
        vec++; if (row_sel !== 8'hFE || col_data !== 8'h00) begin err++; $display("FAIL mr_zero got %h/%h want fe/00", row_sel, col_data); end
        run_to(64);
        vec++; if (frame_done !== 1'b1) begin err++; $display("FAIL mr_fd got %b want 1", frame_done); end
        run_to(67);
        vec++; if (row_sel !== 8'hFE || col_data !== 8'h00) begin err++; $display("FAIL mr_repeat got %h/%h want fe/00", row_sel, col_data); end
        run_to(70);
        row_1_main = 8'h77;
        display = 1'b1;
        run_to(131);
        vec++; if (row_sel !== 8'hFE || col_data !== 8'h77) begin err++; $display("FAIL mr_new got %h/%h want fe/77", row_sel, col_data); end
        run_to(140);
        row_1_main = 8'h99;
        run_to(195);
        vec++; if (row_sel !== 8'hFE || col_data !== 8'h77) begin err++; $display("FAIL held_display got %h/%h want fe/77", row_sel, col_data); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_swap_timing();
        test_coincidence();
        test_overrun();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
